// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
`timescale 1ns/1ps
package seq_mult_pkg;

   typedef enum logic {IDLE, CALC} state_e;

   localparam int MAX_WIDTH = 16;

   // Product is always twice the operand width; used to size the result path.
   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

   // Magnitude of a value when sign is set; the most-negative value maps to 2^(w-1).
   function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] value,
                                                  input logic sign);
      return sign ? (~value + 1'b1) : value;
   endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequencer for seq_mult_core: state, iteration count, busy/done and completion.
// Early completion is compiled in only with SEQ_MULT_EARLY_TERM_EN.
`timescale 1ns/1ps
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
`ifdef SEQ_MULT_EARLY_TERM_EN
   input  logic             idleZero_i,
   input  logic             calcZero_i,
   output logic [CNT_W-1:0] cnt_o,
`endif
   output logic             load_o,
   output logic             step_o,
   output logic             finish_o,
   output logic             busy_o,
   output logic             done_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q;
   logic             lastStep;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_o   = 1'b0;
      step_o   = 1'b0;
      finish_o = 1'b0;
      lastStep = (cnt_q == CNT_W'(1));
`ifdef SEQ_MULT_EARLY_TERM_EN
      lastStep = lastStep | calcZero_i;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               load_o  = 1'b1;
               cnt_d   = CNT_W'(WIDTH);
               state_d = CALC;
`ifdef SEQ_MULT_EARLY_TERM_EN
               // A zero multiplier finishes on the accepting edge itself.
               if (idleZero_i) begin
                  finish_o = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end
`endif
            end
         end
         CALC: begin
            step_o = 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (lastStep) begin
               finish_o = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= finish_o;
      end
   end

   assign busy_o = (state_q == CALC);
   assign done_o = done_q;
`ifdef SEQ_MULT_EARLY_TERM_EN
   assign cnt_o  = cnt_q;
`endif

endmodule

// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier, unsigned or signed per operation, start/busy/done handshake.
// Optional early termination on exhausted multiplier bits: SEQ_MULT_EARLY_TERM_EN.
`timescale 1ns/1ps
module seq_mult_core
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PROD_W = prod_width(WIDTH);

   logic               signA, signB;
   logic [WIDTH-1:0]   magA, magB;
   logic [WIDTH-1:0]   mcand_q, mplier_q, mplier_d;
   logic [WIDTH:0]     acc_q, acc_d, accSum;
   logic [2*WIDTH:0]   shifted;
   logic [PROD_W-1:0]  magProd, productNext, product_q;
   logic               neg_q;
   logic               load, step, finish;
`ifdef SEQ_MULT_EARLY_TERM_EN
   logic [CNT_W-1:0]   cnt;
   logic               idleZero, calcZero;
`endif

   seq_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
`ifdef SEQ_MULT_EARLY_TERM_EN
      .idleZero_i (idleZero),
      .calcZero_i (calcZero),
      .cnt_o      (cnt),
`endif
      .load_o     (load),
      .step_o     (step),
      .finish_o   (finish),
      .busy_o     (busy),
      .done_o     (done)
   );

   // One shift-add iteration; the acc keeps its carry bit before the joint right shift.
   always_comb begin
      signA    = signed_mode & op_a[WIDTH-1];
      signB    = signed_mode & op_b[WIDTH-1];
      magA     = WIDTH'(abs_w(MAX_WIDTH'(op_a), signA));
      magB     = WIDTH'(abs_w(MAX_WIDTH'(op_b), signB));
      accSum   = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      shifted  = {accSum, mplier_q} >> 1;
      acc_d    = shifted[2*WIDTH:WIDTH];
      mplier_d = shifted[WIDTH-1:0];
`ifdef SEQ_MULT_EARLY_TERM_EN
      magProd  = PROD_W'(shifted >> (cnt - 1'b1));
      idleZero = (magB == '0);
      calcZero = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         if ((CNT_W'(i) < cnt) && mplier_q[i]) calcZero = 1'b0;
      end
`else
      magProd  = shifted[PROD_W-1:0];
`endif
      productNext = '0;
      if (step) productNext = neg_q ? (~magProd + 1'b1) : magProd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         if (load) begin
            mcand_q  <= magA;
            mplier_q <= magB;
            acc_q    <= '0;
            neg_q    <= signA ^ signB;
         end else if (step) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
         end
         if (finish) product_q <= productNext;
      end
   end

   assign product = product_q;

endmodule
